// File: rtl/axi_lite_mem_responder.sv
// AXI4-Lite responder in front of a word-addressed RAM. It serves one transaction at a time,
// applies byte strobes, and answers SLVERR for misaligned and DECERR for out-of-range addresses.
module axi_lite_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] s_araddr,
    input  logic [2:0]  s_arprot,
    input  logic        s_arvalid,
    output logic        s_arready,
    output logic [31:0] s_rdata,
    output logic [1:0]  s_rresp,
    output logic        s_rvalid,
    input  logic        s_rready,
    input  logic [31:0] s_awaddr,
    input  logic [2:0]  s_awprot,
    input  logic        s_awvalid,
    output logic        s_awready,
    input  logic [31:0] s_wdata,
    input  logic [3:0]  s_wstrb,
    input  logic        s_wvalid,
    output logic        s_wready,
    output logic [1:0]  s_bresp,
    output logic        s_bvalid,
    input  logic        s_bready
);
    localparam int unsigned IDX_W      = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN_BYTES = 33'(DEPTH_WORDS) << 2;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_R_RESP    = 3'd1;
    localparam logic [2:0] S_W_COLLECT = 3'd2;
    localparam logic [2:0] S_W_EXEC    = 3'd3;
    localparam logic [2:0] S_W_RESP    = 3'd4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Misalignment is checked first so it wins over an out-of-range offset.
    function automatic logic [1:0] decode_resp(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE_ADDR;
        if (addr[1:0] != 2'b00)
            decode_resp = RESP_SLVERR;
        else if ({1'b0, off} >= SPAN_BYTES)
            decode_resp = RESP_DECERR;
        else
            decode_resp = RESP_OKAY;
    endfunction

    logic [31:0] mem [DEPTH_WORDS];

    logic [2:0]       state_reg;
    logic             aw_got_reg;
    logic             w_got_reg;
    logic [31:0]      awaddr_reg;
    logic [31:0]      wdata_reg;
    logic [3:0]       wstrb_reg;
    logic [31:0]      rdata_reg;
    logic [1:0]       rresp_reg;
    logic             rvalid_reg;
    logic [1:0]       bresp_reg;
    logic             bvalid_reg;

    logic             in_idle;
    logic             aw_hs;
    logic             w_hs;
    logic             aw_have;
    logic             w_have;
    logic [1:0]       rd_resp;
    logic [IDX_W-1:0] rd_idx;
    logic [1:0]       wr_resp;
    logic [IDX_W-1:0] wr_idx;
    logic             mem_we;
    logic [3:0]       byte_we;
    logic             unused_prot;

    assign unused_prot = &{1'b0, s_arprot, s_awprot};

    assign in_idle   = rstn && (state_reg == S_IDLE);
    assign s_arready = in_idle;
    assign s_awready = (in_idle && !s_arvalid) || (rstn && state_reg == S_W_COLLECT && !aw_got_reg);
    assign s_wready  = (in_idle && !s_arvalid) || (rstn && state_reg == S_W_COLLECT && !w_got_reg);

    assign aw_hs   = s_awvalid && s_awready;
    assign w_hs    = s_wvalid && s_wready;
    assign aw_have = aw_got_reg || aw_hs;
    assign w_have  = w_got_reg || w_hs;

    assign rd_resp = decode_resp(s_araddr);
    assign rd_idx  = IDX_W'((s_araddr - BASE_ADDR) >> 2);
    assign wr_resp = decode_resp(awaddr_reg);
    assign wr_idx  = IDX_W'((awaddr_reg - BASE_ADDR) >> 2);

    // A reset asserted in the execute cycle suppresses the write entirely.
    assign mem_we = rstn && (state_reg == S_W_EXEC) && (wr_resp == RESP_OKAY);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_byte_we
            assign byte_we[gi] = mem_we && wstrb_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (byte_we[b])
                mem[wr_idx][8*b +: 8] <= wdata_reg[8*b +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (aw_hs)
            awaddr_reg <= s_awaddr;
        if (w_hs) begin
            wdata_reg <= s_wdata;
            wstrb_reg <= s_wstrb;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg  <= S_IDLE;
            aw_got_reg <= 1'b0;
            w_got_reg  <= 1'b0;
            rdata_reg  <= 32'h0;
            rresp_reg  <= RESP_OKAY;
            rvalid_reg <= 1'b0;
            bresp_reg  <= RESP_OKAY;
            bvalid_reg <= 1'b0;
        end else begin
            if (aw_hs)
                aw_got_reg <= 1'b1;
            if (w_hs)
                w_got_reg <= 1'b1;
            case (state_reg)
                S_IDLE: begin
                    if (s_arvalid) begin
                        rresp_reg  <= rd_resp;
                        rdata_reg  <= (rd_resp == RESP_OKAY) ? mem[rd_idx] : 32'h0;
                        rvalid_reg <= 1'b1;
                        state_reg  <= S_R_RESP;
                    end else if (aw_have && w_have) begin
                        state_reg <= S_W_EXEC;
                    end else if (aw_hs || w_hs) begin
                        state_reg <= S_W_COLLECT;
                    end
                end
                S_R_RESP: begin
                    if (s_rready) begin
                        rvalid_reg <= 1'b0;
                        state_reg  <= S_IDLE;
                    end
                end
                S_W_COLLECT: begin
                    if (aw_have && w_have)
                        state_reg <= S_W_EXEC;
                end
                S_W_EXEC: begin
                    bresp_reg  <= wr_resp;
                    bvalid_reg <= 1'b1;
                    state_reg  <= S_W_RESP;
                end
                S_W_RESP: begin
                    if (s_bready) begin
                        bvalid_reg <= 1'b0;
                        aw_got_reg <= 1'b0;
                        w_got_reg  <= 1'b0;
                        state_reg  <= S_IDLE;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign s_rdata  = rdata_reg;
    assign s_rresp  = rresp_reg;
    assign s_rvalid = rvalid_reg;
    assign s_bresp  = bresp_reg;
    assign s_bvalid = bvalid_reg;
endmodule

// File: tb/tb_axi_lite_mem_responder.sv
// Self-checking bench for axi_lite_mem_responder: directed vector table, multi-cycle corner
// sequences, and randomized traffic checked against a simple word-array memory model.
module tb_axi_lite_mem_responder;
    localparam int          DEPTH = 64;
    localparam logic [31:0] BASE  = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] s_araddr = '0;
    logic [2:0]  s_arprot = '0;
    logic        s_arvalid = 1'b0;
    logic        s_arready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rvalid;
    logic        s_rready = 1'b0;
    logic [31:0] s_awaddr = '0;
    logic [2:0]  s_awprot = '0;
    logic        s_awvalid = 1'b0;
    logic        s_awready;
    logic [31:0] s_wdata = '0;
    logic [3:0]  s_wstrb = '0;
    logic        s_wvalid = 1'b0;
    logic        s_wready;
    logic [1:0]  s_bresp;
    logic        s_bvalid;
    logic        s_bready = 1'b0;

    axi_lite_mem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rstn(rstn),
        .s_araddr(s_araddr), .s_arprot(s_arprot), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .s_awaddr(s_awaddr), .s_awprot(s_awprot), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] model_mem [DEPTH];

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          wdly;
        int          stall;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
        int          exp_lat;
    } vec_t;

    vec_t vecs [18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic longint unsigned addr_off(input logic [31:0] a);
        return ({32'd0, a} + 64'h1_0000_0000 - {32'd0, BASE}) % 64'h1_0000_0000;
    endfunction

    function automatic logic [1:0] model_resp(input logic [31:0] a);
        if (a % 4 != 0) return 2'b10;
        if (addr_off(a) >= longint'(DEPTH * 4)) return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (model_resp(a) != 2'b00) return 32'h0;
        return model_mem[int'(addr_off(a) / 4)];
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] strb);
        int idx;
        if (model_resp(a) == 2'b00) begin
            idx = int'(addr_off(a) / 4);
            for (int b = 0; b < 4; b++)
                if (strb[b]) model_mem[idx][8*b +: 8] = d[8*b +: 8];
        end
    endtask

    // Called at posedge+1; returns at posedge+1. lat counts cycles from the first AW drive.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int wdly, input int bstall, output logic [1:0] resp, output int lat);
        int cyc;
        int n;
        bit aw_done;
        bit w_done;
        cyc = 0; aw_done = 0; w_done = 0;
        s_awaddr = addr; s_wdata = data; s_wstrb = strb;
        while (!(aw_done && w_done) && cyc < 100) begin
            s_awvalid = !aw_done;
            s_wvalid  = !w_done && (cyc >= wdly);
            @(negedge clk);
            if (s_awvalid && s_awready) aw_done = 1;
            if (s_wvalid && s_wready) w_done = 1;
            @(posedge clk); #1;
            cyc++;
        end
        s_awvalid = 0; s_wvalid = 0;
        n = 0;
        while (!s_bvalid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("bvalid_seen", 32'(s_bvalid), 32'd1);
        lat = cyc + n;
        resp = s_bresp;
        for (int i = 0; i < bstall; i++) begin
            @(posedge clk); #1;
            chk("bvalid_hold", 32'(s_bvalid), 32'd1);
            chk("bresp_hold", 32'(s_bresp), 32'(resp));
        end
        s_bready = 1;
        @(posedge clk); #1;
        s_bready = 0;
        chk("bvalid_clear", 32'(s_bvalid), 32'd0);
        $display("WR addr=%h data=%h strb=%h wdly=%0d bresp=%0d lat=%0d", addr, data, strb, wdly, resp, lat);
    endtask

    // lat counts cycles from the AR handshake to the first cycle with rvalid.
    task automatic do_read(input logic [31:0] addr, input int rstall,
                           output logic [31:0] data, output logic [1:0] resp, output int lat);
        int cyc;
        int n;
        bit done;
        cyc = 0; done = 0;
        s_araddr = addr; s_arvalid = 1;
        while (!done && cyc < 100) begin
            @(negedge clk);
            if (s_arready) done = 1;
            @(posedge clk); #1;
            cyc++;
        end
        s_arvalid = 0;
        chk("ar_accepted", 32'(done), 32'd1);
        n = 0;
        while (!s_rvalid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("rvalid_seen", 32'(s_rvalid), 32'd1);
        lat = n + 1;
        data = s_rdata; resp = s_rresp;
        for (int i = 0; i < rstall; i++) begin
            @(posedge clk); #1;
            chk("rvalid_hold", 32'(s_rvalid), 32'd1);
            chk("rdata_hold", s_rdata, data);
            chk("rresp_hold", 32'(s_rresp), 32'(resp));
        end
        s_rready = 1;
        @(posedge clk); #1;
        s_rready = 0;
        chk("rvalid_clear", 32'(s_rvalid), 32'd0);
        $display("RD addr=%h rdata=%h rresp=%0d lat=%0d", addr, data, resp, lat);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [1:0]  resp;
        logic [31:0] data;
        logic [31:0] a;
        logic [31:0] old;
        int          lat;
        int          n;

        vecs[0]  = '{1'b1, 32'h0000_1010, 32'hDEAD_BEEF, 4'hF, 0, 0, 2'b00, 32'h0, 2};
        vecs[1]  = '{1'b0, 32'h0000_1010, 32'h0, 4'h0, 0, 0, 2'b00, 32'hDEAD_BEEF, 1};
        vecs[2]  = '{1'b1, 32'h0000_1010, 32'h1122_3344, 4'b0101, 0, 1, 2'b00, 32'h0, 2};
        vecs[3]  = '{1'b0, 32'h0000_1010, 32'h0, 4'h0, 0, 5, 2'b00, 32'hDE22_BE44, 1};
        vecs[4]  = '{1'b0, 32'h0000_1002, 32'h0, 4'h0, 0, 0, 2'b10, 32'h0, 1};
        vecs[5]  = '{1'b0, 32'h0000_1100, 32'h0, 4'h0, 0, 0, 2'b11, 32'h0, 1};
        vecs[6]  = '{1'b0, 32'h0000_1010, 32'h0, 4'h0, 0, 0, 2'b00, 32'hDE22_BE44, 1};
        vecs[7]  = '{1'b1, 32'h0000_1013, 32'hFFFF_FFFF, 4'hF, 0, 0, 2'b10, 32'h0, 2};
        vecs[8]  = '{1'b1, 32'h0000_0FFC, 32'hFFFF_FFFF, 4'hF, 0, 0, 2'b11, 32'h0, 2};
        vecs[9]  = '{1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 4'hF, 2, 0, 2'b11, 32'h0, 4};
        vecs[10] = '{1'b0, 32'h0000_1010, 32'h0, 4'h0, 0, 0, 2'b00, 32'hDE22_BE44, 1};
        vecs[11] = '{1'b1, 32'h0000_1010, 32'hFFFF_FFFF, 4'h0, 0, 0, 2'b00, 32'h0, 2};
        vecs[12] = '{1'b0, 32'h0000_1010, 32'h0, 4'h0, 0, 0, 2'b00, 32'hDE22_BE44, 1};
        vecs[13] = '{1'b1, 32'h0000_1020, 32'hA5A5_0F0F, 4'hF, 3, 0, 2'b00, 32'h0, 5};
        vecs[14] = '{1'b0, 32'h0000_1020, 32'h0, 4'h0, 0, 0, 2'b00, 32'hA5A5_0F0F, 1};
        vecs[15] = '{1'b1, 32'h0000_10FC, 32'hCAFE_F00D, 4'hF, 1, 2, 2'b00, 32'h0, 3};
        vecs[16] = '{1'b0, 32'h0000_10FC, 32'h0, 4'h0, 0, 0, 2'b00, 32'hCAFE_F00D, 1};
        vecs[17] = '{1'b0, 32'h0000_1101, 32'h0, 4'h0, 0, 0, 2'b10, 32'h0, 1};

        // Reset: every ready and valid low even with all requests asserted.
        rstn = 0;
        repeat (3) @(posedge clk);
        #1;
        s_arvalid = 1; s_awvalid = 1; s_wvalid = 1;
        @(negedge clk);
        chk("rst_arready", 32'(s_arready), 32'd0);
        chk("rst_awready", 32'(s_awready), 32'd0);
        chk("rst_wready", 32'(s_wready), 32'd0);
        chk("rst_rvalid", 32'(s_rvalid), 32'd0);
        chk("rst_bvalid", 32'(s_bvalid), 32'd0);
        chk("rst_rdata", s_rdata, 32'h0);
        chk("rst_rresp", 32'(s_rresp), 32'd0);
        chk("rst_bresp", 32'(s_bresp), 32'd0);
        @(posedge clk); #1;
        s_arvalid = 0; s_awvalid = 0; s_wvalid = 0;
        rstn = 1;
        @(posedge clk); #1;

        // Give every word a known value.
        for (int i = 0; i < DEPTH; i++) begin
            data = $urandom;
            a = BASE + 32'(4 * i);
            do_write(a, data, 4'hF, 0, 0, resp, lat);
            chk("init_bresp", 32'(resp), 32'd0);
            model_write(a, data, 4'hF);
        end

        for (int i = 0; i < 18; i++) begin
            if (vecs[i].is_wr) begin
                do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].wdly, vecs[i].stall, resp, lat);
                chk($sformatf("vec%0d_bresp", i), 32'(resp), 32'(vecs[i].exp_resp));
                chk($sformatf("vec%0d_wlat", i), 32'(lat), 32'(vecs[i].exp_lat));
                model_write(vecs[i].addr, vecs[i].data, vecs[i].strb);
            end else begin
                do_read(vecs[i].addr, vecs[i].stall, data, resp, lat);
                chk($sformatf("vec%0d_rresp", i), 32'(resp), 32'(vecs[i].exp_resp));
                chk($sformatf("vec%0d_rdata", i), data, vecs[i].exp_rdata);
                chk($sformatf("vec%0d_rlat", i), 32'(lat), 32'(vecs[i].exp_lat));
            end
        end

        // AW in cycle 0, W in cycle 3.
        s_awaddr = BASE + 32'h30; s_wdata = 32'h0BAD_F00D; s_wstrb = 4'hF; s_awvalid = 1;
        for (int c = 0; c <= 5; c++) begin
            if (c == 3) s_wvalid = 1;
            @(negedge clk);
            if (c <= 3) chk($sformatf("late_w_wready_c%0d", c), 32'(s_wready), 32'd1);
            chk($sformatf("late_w_awready_c%0d", c), 32'(s_awready), 32'(c == 0));
            chk($sformatf("late_w_bvalid_c%0d", c), 32'(s_bvalid), 32'(c == 5));
            @(posedge clk); #1;
            if (c == 0) s_awvalid = 0;
            if (c == 3) s_wvalid = 0;
        end
        chk("late_w_bresp", 32'(s_bresp), 32'd0);
        s_bready = 1;
        @(posedge clk); #1;
        s_bready = 0;
        model_write(BASE + 32'h30, 32'h0BAD_F00D, 4'hF);
        $display("WR addr=%h data=%h late W sequence", BASE + 32'h30, 32'h0BAD_F00D);
        do_read(BASE + 32'h30, 0, data, resp, lat);
        chk("late_w_readback", data, 32'h0BAD_F00D);

        // AR and AW/W in the same cycle: the read goes first.
        old = model_read(BASE + 32'h50);
        s_araddr = BASE + 32'h50; s_arvalid = 1;
        s_awaddr = BASE + 32'h50; s_wdata = 32'h5A5A_1234; s_wstrb = 4'hF;
        s_awvalid = 1; s_wvalid = 1;
        @(negedge clk);
        chk("race_arready", 32'(s_arready), 32'd1);
        chk("race_awready", 32'(s_awready), 32'd0);
        chk("race_wready", 32'(s_wready), 32'd0);
        @(posedge clk); #1;
        s_arvalid = 0; s_rready = 1;
        @(negedge clk);
        chk("race_rvalid", 32'(s_rvalid), 32'd1);
        chk("race_rdata_old", s_rdata, old);
        chk("race_awready_rresp", 32'(s_awready), 32'd0);
        @(posedge clk); #1;
        s_rready = 0;
        @(negedge clk);
        chk("race_awready_after", 32'(s_awready), 32'd1);
        chk("race_wready_after", 32'(s_wready), 32'd1);
        @(posedge clk); #1;
        s_awvalid = 0; s_wvalid = 0;
        model_write(BASE + 32'h50, 32'h5A5A_1234, 4'hF);
        n = 0;
        while (!s_bvalid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("race_blat", 32'(n), 32'd1);
        chk("race_bresp", 32'(s_bresp), 32'd0);
        s_bready = 1;
        @(posedge clk); #1;
        s_bready = 0;
        $display("RD+WR addr=%h read=%h then wrote %h", BASE + 32'h50, old, 32'h5A5A_1234);
        do_read(BASE + 32'h50, 0, data, resp, lat);
        chk("race_readback", data, 32'h5A5A_1234);

        // Reset while a read response is pending.
        s_araddr = BASE + 32'h20; s_arvalid = 1;
        @(posedge clk); #1;
        s_arvalid = 0;
        chk("rstr_rvalid_before", 32'(s_rvalid), 32'd1);
        rstn = 0;
        @(posedge clk); #1;
        rstn = 1;
        chk("rstr_rvalid", 32'(s_rvalid), 32'd0);
        chk("rstr_rdata", s_rdata, 32'h0);
        $display("RD addr=%h abandoned by reset", BASE + 32'h20);

        // Reset while waiting for W: no write may land.
        old = model_read(BASE + 32'h40);
        s_awaddr = BASE + 32'h40; s_awvalid = 1; s_wdata = ~old; s_wstrb = 4'hF;
        @(negedge clk);
        chk("rstw_awready", 32'(s_awready), 32'd1);
        @(posedge clk); #1;
        s_awvalid = 0; s_wvalid = 1; rstn = 0;
        @(negedge clk);
        chk("rstw_wready", 32'(s_wready), 32'd0);
        @(posedge clk); #1;
        s_wvalid = 0; rstn = 1;
        chk("rstw_rvalid", 32'(s_rvalid), 32'd0);
        chk("rstw_bvalid", 32'(s_bvalid), 32'd0);
        @(negedge clk);
        chk("rstw_arready", 32'(s_arready), 32'd1);
        @(posedge clk); #1;
        chk("rstw_bvalid_later", 32'(s_bvalid), 32'd0);
        $display("WR addr=%h abandoned by reset", BASE + 32'h40);
        do_read(BASE + 32'h40, 0, data, resp, lat);
        chk("rstw_unchanged", data, old);

        // Randomized traffic against the model.
        for (int i = 0; i < 200; i++) begin
            int sel;
            int wd;
            int st;
            logic [3:0] strb;
            sel = int'($urandom_range(0, 9));
            if (sel < 7)       a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
            else if (sel == 7) a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(1, 3));
            else if (sel == 8) a = BASE + 32'(DEPTH * 4) + 32'(4 * $urandom_range(0, 63));
            else               a = $urandom;
            st = int'($urandom_range(0, 2));
            if ($urandom_range(0, 1) == 1) begin
                data = $urandom;
                strb = 4'($urandom_range(0, 15));
                wd = int'($urandom_range(0, 3));
                do_write(a, data, strb, wd, st, resp, lat);
                chk("rnd_bresp", 32'(resp), 32'(model_resp(a)));
                chk("rnd_wlat", 32'(lat), 32'(wd + 2));
                model_write(a, data, strb);
            end else begin
                do_read(a, st, data, resp, lat);
                chk("rnd_rresp", 32'(resp), 32'(model_resp(a)));
                chk("rnd_rdata", data, model_read(a));
                chk("rnd_rlat", 32'(lat), 32'd1);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/axi_lite_mem_responder.md
# axi_lite_mem_responder

AXI4-Lite responder (slave) fronting a word-addressed on-chip RAM. It answers the read/write transactions issued by the core's memory interface master, so instruction fetch and load/store traffic can be simulated and synthesized without an external interconnect. It handles one transaction at a time, applies byte strobes, and returns error responses for misaligned or out-of-range addresses.

## Interface
- DEPTH_WORDS, 1024: RAM size in 32-bit words; power of two.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; aligned to DEPTH_WORDS*4.
- clk  in  1  clock
- rstn  in  1  synchronous, active-low reset
- s_araddr  in  32  read address
- s_arprot  in  3  ignored
- s_arvalid  in  1  read address valid
- s_arready  out  1  read address ready
- s_rdata  out  32  read data
- s_rresp  out  2  read response
- s_rvalid  out  1  read data valid
- s_rready  in  1  read data ready
- s_awaddr  in  32  write address
- s_awprot  in  3  ignored
- s_awvalid  in  1  write address valid
- s_awready  out  1  write address ready
- s_wdata  in  32  write data
- s_wstrb  in  4  byte enables; bit i enables wdata[8i+7:8i]
- s_wvalid  in  1  write data valid
- s_wready  out  1  write data ready
- s_bresp  out  2  write response
- s_bvalid  out  1  write response valid
- s_bready  in  1  write response ready

## Operation
- States: IDLE, R_RESP, W_COLLECT, W_EXEC, W_RESP.
- Ready outputs are combinational from state and valid inputs; all are 0 while rstn is low.
  - s_arready = (state==IDLE).
  - s_awready = (IDLE && !s_arvalid) || (W_COLLECT && !aw_got).
  - s_wready = (IDLE && !s_arvalid) || (W_COLLECT && !w_got).
  - Read wins when AR and AW/W are valid in the same IDLE cycle.
- IDLE, AR handshake: decode address, load s_rdata/s_rresp, s_rvalid<=1, go to R_RESP.
- IDLE, AW and/or W handshake: capture addr, data and strb; set aw_got/w_got. Both captured goes to W_EXEC; otherwise go to W_COLLECT.
- W_COLLECT: accept the missing channel. Once both are captured, go to W_EXEC.
- W_EXEC: if response is OKAY, write the strobed bytes. Unstrobed bytes are unchanged; wstrb=0 writes nothing and still returns OKAY. Then s_bvalid<=1, load s_bresp, go to W_RESP.
- R_RESP: hold s_rdata/s_rresp/s_rvalid stable until s_rready; on handshake, s_rvalid<=0, go to IDLE.
- W_RESP: hold until s_bready; on handshake, s_bvalid<=0, clear aw_got/w_got, go to IDLE.
- Address decode (off = addr - BASE_ADDR, 32-bit unsigned wrap):
  - addr[1:0]!=0 gives SLVERR (2'b10).
  - off >= DEPTH_WORDS*4 gives DECERR (2'b11); misalignment takes precedence.
  - Otherwise OKAY (2'b00); word index = off[log2(DEPTH_WORDS)+1:2].
  - On error: s_rdata = 0, no RAM write.
- Reset: state=IDLE; s_rvalid=0, s_bvalid=0, s_rresp=0, s_bresp=0, s_rdata=0; got flags cleared. RAM contents are preserved. Reset mid-transaction abandons it with no partial write unless W_EXEC already completed.

## Timing
- Read: AR handshake at edge N, so s_rvalid=1 with data in cycle N+1. If s_rready=1, the handshake completes at edge N+1. s_arready returns in cycle N+2; minimum 2 cycles per read.
- Write, AW and W together at edge N: W_EXEC in cycle N+1; RAM updated and s_bvalid=1 at edge N+1. Minimum 3 cycles per write.
- A W arriving k cycles after AW delays s_bvalid by k cycles.
- A read issued after the B handshake returns the new data.
- Backpressure: s_rvalid/s_bvalid and payload remain stable for any number of stall cycles.

## Test plan
- Write 0xDEADBEEF at BASE+0x10, wstrb=4'hF, AW and W together, then read BASE+0x10. Expect s_bvalid at N+1, bresp=00; rdata=0xDEADBEEF at N+1 after AR, rresp=00.
- Partial strobe: after the write above, write 0x11223344 with wstrb=4'b0101, then read back. Expect 0xDE22BE44.
- AW at cycle 0 and W at cycle 3. Expect s_wready high in cycles 0–3, s_awready low in cycles 1–3, s_bvalid at cycle 5.
- Reads at BASE+0x2 and BASE+DEPTH_WORDS*4. Expect rresp=10 and rresp=11 respectively, rdata=0. A following OKAY read shows memory unchanged.
- AR and AW/W valid in the same cycle. Expect read served first, with s_awready=0 that cycle; write completes after the R handshake.
- Hold s_rready=0 for 5 cycles. Expect s_rvalid/s_rdata stable. Assert rstn=0 during W_COLLECT. Expect all valids 0 next cycle and no RAM change.
